// File: rtl/main_memory.sv
// main_memory: word-addressed synchronous memory with burst read/write access.
// Ports:
//   clk       - single clock, all state changes on its rising edge
//   rst_n     - synchronous active-low reset (memory contents are kept)
//   enable    - request strobe, sampled only while idle
//   rw        - 0 = read, 1 = write
//   acc_size  - burst length code: 00=1, 01=4, 10=8, 11=16 beats
//   address   - byte address of the first beat (must be word aligned)
//   data_in   - write data for the current write beat
//   data_out  - read data, zero whenever no read beat is presented
//   valid     - data_out carries a read beat this cycle
//   busy      - burst in progress, new requests ignored
//   err       - one-cycle pulse for a misaligned request or out-of-range beat
module main_memory #(
    parameter logic [31:0] BASE_ADDR   = 32'h80020000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        rw,
    input  logic [1:0]  acc_size,
    input  logic [0:31] address,
    input  logic [0:31] data_in,
    output logic [0:31] data_out,
    output logic        valid,
    output logic        busy,
    output logic        err
);

    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W  = 5;
    localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_ADDR = 33'(BASE_ADDR) + 33'(DEPTH_WORDS) * 33'd4 - 33'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   beats_q;
    logic [31:0]        addr_q;

    logic [31:0]        mem [DEPTH_WORDS];

    logic [31:0]        beat_addr_c;
    logic               in_range_c;
    logic [IDX_W-1:0]   idx_c;
    logic [31:0]        rd_word_c;
    logic               aligned_c;
    logic               mem_we_c;

    // Burst length decode.
    function automatic logic [CNT_W-1:0] beats_of(input logic [1:0] code);
        case (code)
            2'b00:   beats_of = CNT_W'(1);
            2'b01:   beats_of = CNT_W'(4);
            2'b10:   beats_of = CNT_W'(8);
            default: beats_of = CNT_W'(16);
        endcase
    endfunction

    // Current beat address: the live request while idle, latched base + 4*cnt in a burst.
    always_comb begin
        beat_addr_c = 32'(address);
        if (state != IDLE) begin
            beat_addr_c = addr_q + 32'({cnt, 2'b00});
        end
        in_range_c = ({1'b0, beat_addr_c} >= LO_ADDR) && ({1'b0, beat_addr_c} <= HI_ADDR);
        idx_c      = IDX_W'((beat_addr_c - BASE_ADDR) >> 2);
        rd_word_c  = in_range_c ? mem[idx_c] : 32'd0;
        aligned_c  = (address[30:31] == 2'b00);
        mem_we_c   = rst_n && in_range_c &&
                     (((state == IDLE) && enable && rw && aligned_c) || (state == WR_BURST));
    end

    // Storage array; reset deliberately leaves contents alone.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_c] <= 32'(data_in);
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
            cnt      <= '0;
            beats_q  <= '0;
            addr_q   <= '0;
        end else begin
            valid    <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (!aligned_c) begin
                            err <= 1'b1;
                        end else begin
                            addr_q  <= 32'(address);
                            beats_q <= beats_of(acc_size);
                            err     <= !in_range_c;
                            if (!rw) begin
                                // Beat 0 is presented in the first burst cycle.
                                state    <= RD_BURST;
                                busy     <= 1'b1;
                                cnt      <= CNT_W'(1);
                                valid    <= 1'b1;
                                data_out <= rd_word_c;
                            end else if (beats_of(acc_size) != CNT_W'(1)) begin
                                state <= WR_BURST;
                                busy  <= 1'b1;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                end
                RD_BURST: begin
                    if (cnt < beats_q) begin
                        valid    <= 1'b1;
                        data_out <= rd_word_c;
                        err      <= !in_range_c;
                        cnt      <= cnt + CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                WR_BURST: begin
                    // Write error shows up the cycle after the discarded beat.
                    err <= !in_range_c;
                    if (cnt == beats_q - CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed bench for main_memory with a read-beat scoreboard
// and a reference memory model.
module tb_main_memory;

    localparam logic [31:0] BASE  = 32'h80020000;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        rw;
    logic [1:0]  acc_size;
    logic [0:31] address;
    logic [0:31] data_in;
    logic [0:31] data_out;
    logic        valid;
    logic        busy;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_d [$];
    logic        exp_e [$];

    main_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .rw       (rw),
        .acc_size (acc_size),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic int nbeats(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic inr(input logic [31:0] a);
        return (a >= BASE) && ({1'b0, a} <= {1'b0, BASE} + 33'(DEPTH * 4 - 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // One clock; outputs are checked 1 time unit after the edge.
    task automatic tick(input logic eb, input logic ee, input string tag);
        logic [31:0] d;
        logic        e;
        @(posedge clk);
        #1;
        vectors++;
        assert (busy === eb) else begin
            miscompares++;
            $error("FAIL %s busy: got %b want %b", tag, busy, eb);
        end
        if (valid === 1'b1) begin
            vectors++;
            assert (exp_d.size() > 0) else begin
                miscompares++;
                $error("FAIL %s unexpected beat: got data %h want no beat", tag, data_out);
            end
            if (exp_d.size() > 0) begin
                d = exp_d.pop_front();
                e = exp_e.pop_front();
                vectors++;
                assert (32'(data_out) === d) else begin
                    miscompares++;
                    $error("FAIL %s data_out: got %h want %h", tag, data_out, d);
                end
                vectors++;
                assert (err === e) else begin
                    miscompares++;
                    $error("FAIL %s beat err: got %b want %b", tag, err, e);
                end
            end
        end else begin
            vectors++;
            assert (valid === 1'b0) else begin
                miscompares++;
                $error("FAIL %s valid: got %b want 0", tag, valid);
            end
            vectors++;
            assert (err === ee) else begin
                miscompares++;
                $error("FAIL %s err: got %b want %b", tag, err, ee);
            end
            vectors++;
            assert (32'(data_out) === 32'd0) else begin
                miscompares++;
                $error("FAIL %s idle data_out: got %h want 00000000", tag, data_out);
            end
        end
    endtask

    task automatic check_drained(input string tag);
        vectors++;
        assert (exp_d.size() == 0) else begin
            miscompares++;
            $error("FAIL %s missing beats: got %0d left want 0", tag, exp_d.size());
        end
    endtask

    // Read burst; poke_k >= 1 raises a stray write request in cycle T+poke_k.
    task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input int poke_k,
                           input string tag);
        int n;
        logic [31:0] ba;
        n = nbeats(sz);
        for (int k = 0; k < n; k++) begin
            ba = a + 32'(4 * k);
            if (inr(ba)) begin
                exp_d.push_back(model[widx(ba)]);
                exp_e.push_back(1'b0);
            end else begin
                exp_d.push_back(32'd0);
                exp_e.push_back(1'b1);
            end
        end
        enable   = 1'b1;
        rw       = 1'b0;
        acc_size = sz;
        address  = a;
        tick(1'b1, 1'b0, tag);
        enable   = 1'b0;
        address  = $urandom();
        acc_size = ~sz;
        for (int k = 1; k < n; k++) begin
            if (k == poke_k) begin
                enable  = 1'b1;
                rw      = 1'b1;
                address = BASE;
                data_in = 32'h12345678;
            end
            tick(1'b1, 1'b0, tag);
            enable = 1'b0;
            rw     = 1'b0;
        end
        tick(1'b0, 1'b0, tag);
        check_drained(tag);
    endtask

    // Write burst of values v0 + step*k.
    task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] v0,
                            input logic [31:0] step, input string tag);
        int n;
        logic [31:0] ba;
        logic [31:0] d;
        n = nbeats(sz);
        for (int k = 0; k < n; k++) begin
            ba = a + 32'(4 * k);
            d  = v0 + step * 32'(k);
            if (k == 0) begin
                enable   = 1'b1;
                rw       = 1'b1;
                acc_size = sz;
                address  = a;
            end else begin
                enable   = 1'b0;
                address  = $urandom();
                acc_size = ~sz;
            end
            data_in = d;
            tick(k < n - 1, !inr(ba), tag);
            if (inr(ba)) model[widx(ba)] = d;
        end
        enable = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        rw       = 1'b0;
        acc_size = 2'b00;
        address  = '0;
        data_in  = '0;
        tick(1'b0, 1'b0, "reset0");
        tick(1'b0, 1'b0, "reset1");
        rst_n = 1'b1;
        tick(1'b0, 1'b0, "post_reset");

        // Single write then read on the next cycle.
        do_write(BASE, 2'b00, 32'hDEADBEEF, 32'd0, "single_wr");
        do_read(BASE, 2'b00, 0, "single_rd");

        // 4-beat read of words 4..7 with a stray request at T+2.
        do_write(BASE + 32'h10, 2'b01, 32'h0000_0040, 32'd1, "wr4");
        do_read(BASE + 32'h10, 2'b01, 2, "rd4_poke");
        do_read(BASE, 2'b00, 0, "poke_ignored");

        // 16-beat write/read of 0..15.
        do_write(BASE + 32'h40, 2'b11, 32'd0, 32'd1, "wr16");
        do_read(BASE + 32'h40, 2'b11, 0, "rd16");

        // 8-beat mixed pattern.
        do_write(BASE + 32'h200, 2'b10, 32'hCAFE_0001, 32'h1111_1111, "wr8");
        do_read(BASE + 32'h200, 2'b10, 0, "rd8");

        // Misaligned read is rejected.
        enable   = 1'b1;
        rw       = 1'b0;
        acc_size = 2'b01;
        address  = BASE + 32'h2;
        tick(1'b0, 1'b1, "misaligned");
        enable = 1'b0;
        tick(1'b0, 1'b0, "misaligned_after");

        // Read running off the top of memory.
        do_write(BASE + 32'hFF8, 2'b00, 32'h5555_AAAA, 32'd0, "top_wr0");
        do_write(BASE + 32'hFFC, 2'b00, 32'hAAAA_5555, 32'd0, "top_wr1");
        do_read(BASE + 32'hFF8, 2'b01, 0, "rd_oor");

        // Out-of-range writes are discarded with err next cycle.
        do_write(BASE + 32'h1000, 2'b00, 32'h0BAD_0BAD, 32'd0, "wr_oor_hi");
        do_write(BASE - 32'h4, 2'b01, 32'h7700_0000, 32'd1, "wr_oor_lo");
        do_read(BASE, 2'b01, 0, "rd_after_oor");

        // Reset aborts an 8-beat write after two beats.
        do_write(BASE + 32'h100, 2'b10, 32'hA000_0000, 32'd1, "prefill");
        enable   = 1'b1;
        rw       = 1'b1;
        acc_size = 2'b10;
        address  = BASE + 32'h100;
        data_in  = 32'hB000_0000;
        tick(1'b1, 1'b0, "abort_b0");
        model[widx(BASE + 32'h100)] = 32'hB000_0000;
        enable  = 1'b0;
        data_in = 32'hB000_0001;
        tick(1'b1, 1'b0, "abort_b1");
        model[widx(BASE + 32'h104)] = 32'hB000_0001;
        rst_n   = 1'b0;
        enable  = 1'b1;
        rw      = 1'b0;
        address = BASE;
        data_in = 32'hB000_0002;
        tick(1'b0, 1'b0, "abort_reset");
        rst_n  = 1'b1;
        enable = 1'b0;
        tick(1'b0, 1'b0, "abort_idle");
        do_read(BASE + 32'h100, 2'b10, 0, "abort_readback");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
